ps2_host_tx: RTL
================

# ps2_host_tx

PS/2 host-to-device transmitter that sends one command byte (LED set 0xED, reset 0xFF, typematic and similar) from the Z80 side to the attached keyboard. It is the opposite direction of the existing PS/2 keyboard receiver and shares the same ps2clk/ps2dat lines through open-collector enables. It performs the request-to-send inhibit, serialises start, data, odd parity and stop, checks the device ACK, and enforces protocol timeouts. While it is active, it flags the receiver to ignore line activity.

## Interface
- INHIBIT_CYCLES, 400: clk cycles ps2clk is held low before start (≥100 µs at 4 MHz).
- FIRST_EDGE_TIMEOUT, 60000: cycles allowed from clock release to first device falling edge (15 ms).
- PACKET_TIMEOUT, 8000: cycles allowed from first falling edge to ACK sampled (2 ms).
- All parameters 1..65535; one 16-bit down-counter serves all three.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid & tx_ready.
- tx_done  out  1  one-cycle pulse at end of transaction (success or failure).
- tx_err  out  1  valid with tx_done; 1 = ACK missing or timeout.
- busy  out  1  high whenever state ≠ IDLE.
- rx_inhibit  out  1  equal to busy; receiver discards frames while high.
- ps2clk_in  in  1  raw ps2clk pin level (asynchronous).
- ps2dat_in  in  1  raw ps2dat pin level (asynchronous).
- ps2clk_oe  out  1  1 = pull ps2clk low, 0 = release.
- ps2dat_oe  out  1  1 = pull ps2dat low, 0 = release.

## Operation
- Inputs pass through 2-flop synchronisers, reset to 1. A falling edge is sync = 0 with previous sync = 1.
- Reset state: IDLE. Reset values: ps2clk_oe=0, ps2dat_oe=0, tx_done=0, tx_err=0, busy=0, rx_inhibit=0, tx_ready=1 from the first cycle after reset.
- Accept: latch tx_data into an 8-bit shift register, latch parity = ~^tx_data (odd), load counter with INHIBIT_CYCLES, go to INHIBIT.
- INHIBIT: clk_oe=1, dat_oe=0. When the counter reaches 0, set dat_oe=1 (start bit) and go to REQ.
- REQ (1 cycle): clk_oe=1, dat_oe=1. Then go to RELEASE: clk_oe=0, counter=FIRST_EDGE_TIMEOUT, bit count=0.
- RELEASE: on the first falling edge, reload counter=PACKET_TIMEOUT and go to SEND.
- SEND: every falling edge, including the first, increments the bit count n and updates the data line while the clock is low:
  - n=1..8: dat_oe = ~data[n-1], LSB first.
  - n=9: dat_oe = ~parity.
  - n=10: dat_oe=0 (stop bit).
  - n=11: sample sync ps2dat; 0 = ACK ok. Go to WAIT_IDLE.
- WAIT_IDLE: both lines released. When sync clk and sync dat are both 1, pulse tx_done with tx_err=~ack_ok and return to IDLE.
- Timeout: counter hits 0 in RELEASE, SEND or WAIT_IDLE (WAIT_IDLE keeps the PACKET counter running). Release both lines the next cycle, pulse tx_done with tx_err=1, return to IDLE.
- tx_valid outside IDLE is ignored, with no queuing.
- Reset mid-transfer: both oe go to 0 at that edge and state goes to IDLE. No tx_done is produced.

## Timing
- Accept to ps2clk_oe=1: 1 cycle.
- ps2clk held low for exactly INHIBIT_CYCLES+1 cycles. ps2dat_oe rises INHIBIT_CYCLES cycles after clk_oe rises.
- Pin falling edge to oe update: 3 cycles (2 sync stages + edge register). Device clock low time ≥30 µs, so the data bit is always settled before the device samples on the rising edge.
- tx_done is a single cycle, never two consecutive cycles. tx_ready returns to 1 the cycle after tx_done.
- Simultaneous timeout and falling edge: timeout wins.

## Test plan
- Send 0xED, device model ACKs: serialised bits 1,0,1,1,0,1,1,1; parity 1; stop 1 → tx_done=1, tx_err=0. Inhibit low for 401 cycles.
- Send 0x01, then 0x00, then 0xFF, each ACKed → parity bits 0, 1, 1 respectively; tx_err=0 each time.
- Send 0xF4, device leaves data high on the 11th clock → tx_done with tx_err=1.
- Device never clocks → tx_err=1 exactly FIRST_EDGE_TIMEOUT cycles after clock release; both oe=0.
- Device stops after 5 clocks → tx_err=1 at PACKET_TIMEOUT after the first edge. tx_valid pulsed mid-frame is ignored (tx_ready=0 during the frame).
- Reset asserted during bit 4 → next cycle oe=0/0, tx_ready=1, no tx_done; a following 0xFF send completes with tx_err=0.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard:
// it holds ps2clk low (request-to-send inhibit), asserts the start bit and
// releases the clock. It then shifts out data LSB first, odd parity and stop
// on each device falling clock edge, and finally samples the device ACK.
// Each protocol phase is covered by a timeout. Both lines are driven
// open-collector through *_oe outputs.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   tx_data/tx_valid  command byte and request; accepted when tx_ready=1
//   tx_ready          high only while idle
//   tx_done/tx_err    one-cycle completion pulse; tx_err=1 on NACK/timeout
//   busy, rx_inhibit  high while a transfer is in progress
//   ps2clk_in/dat_in  raw (asynchronous) pin levels
//   ps2clk_oe/dat_oe  1 = pull the line low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES     = 400,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 60000,
    parameter int unsigned PACKET_TIMEOUT     = 8000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    output logic       rx_inhibit,
    input  logic       ps2clk_in,
    input  logic       ps2dat_in,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe
);

    localparam logic [15:0] INH_LD = 16'(INHIBIT_CYCLES);
    localparam logic [15:0] FET_LD = 16'(FIRST_EDGE_TIMEOUT);
    localparam logic [15:0] PKT_LD = 16'(PACKET_TIMEOUT);

    // DONE is a one-cycle state that carries the tx_done pulse, so tx_ready
    // only comes back the cycle after it.
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        RELEASE,
        SEND,
        WAIT_IDLE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        par_q, par_d;
    logic [3:0]  nbit_q, nbit_d;
    logic        ack_ok_q, ack_ok_d;
    logic        err_q, err_d;
    logic        clk_oe_q, clk_oe_d;
    logic        dat_oe_q, dat_oe_d;

    // Two-stage synchronisers plus an edge register on the clock line.
    logic        clk_s1_q, clk_s2_q, clk_prev_q;
    logic        dat_s1_q, dat_s2_q;

    logic        fall;
    logic        expire;
    logic [3:0]  bit_n;

    assign fall   = clk_prev_q & ~clk_s2_q;
    // The counter "hits 0" on the cycle its decrement would reach zero.
    assign expire = (cnt_q <= 16'd1);
    assign bit_n  = nbit_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            sr_q     <= 8'd0;
            par_q    <= 1'b0;
            nbit_q   <= 4'd0;
            ack_ok_q <= 1'b0;
            err_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            par_q    <= par_d;
            nbit_q   <= nbit_d;
            ack_ok_q <= ack_ok_d;
            err_q    <= err_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        par_d    = par_q;
        nbit_d   = nbit_q;
        ack_ok_d = ack_ok_q;
        err_d    = err_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;

        unique case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid) begin
                    sr_d     = tx_data;
                    par_d    = ~^tx_data;
                    cnt_d    = INH_LD;
                    err_d    = 1'b0;
                    ack_ok_d = 1'b0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end

            INHIBIT: begin
                cnt_d = cnt_q - 16'd1;
                if (expire) begin
                    dat_oe_d = 1'b1;  // start bit
                    state_d  = REQ;
                end
            end

            REQ: begin
                clk_oe_d = 1'b0;
                cnt_d    = FET_LD;
                nbit_d   = 4'd0;
                state_d  = RELEASE;
            end

            // RELEASE and SEND share the bit logic: the first device edge
            // already carries data bit 0 and re-arms the packet timeout.
            RELEASE, SEND: begin
                cnt_d = cnt_q - 16'd1;
                if (expire) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end else if (fall) begin
                    if (state_q == RELEASE) cnt_d = PKT_LD;
                    state_d = SEND;
                    nbit_d  = bit_n;
                    if (bit_n <= 4'd8) begin
                        dat_oe_d = ~sr_q[0];
                        sr_d     = {1'b0, sr_q[7:1]};
                    end else if (bit_n == 4'd9) begin
                        dat_oe_d = ~par_q;
                    end else if (bit_n == 4'd10) begin
                        dat_oe_d = 1'b0;  // stop bit
                    end else begin
                        dat_oe_d = 1'b0;
                        ack_ok_d = ~dat_s2_q;
                        state_d  = WAIT_IDLE;
                    end
                end
            end

            // Packet counter keeps running until both lines float high.
            WAIT_IDLE: begin
                cnt_d    = cnt_q - 16'd1;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (expire) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (clk_s2_q && dat_s2_q) begin
                    err_d   = ~ack_ok_q;
                    state_d = DONE;
                end
            end

            DONE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign tx_ready   = (state_q == IDLE);
    assign tx_done    = (state_q == DONE);
    assign tx_err     = (state_q == DONE) & err_q;
    assign busy       = (state_q != IDLE);
    assign rx_inhibit = busy;
    assign ps2clk_oe  = clk_oe_q;
    assign ps2dat_oe  = dat_oe_q;

endmodule
